tdp_ram_port_arbiter: RTL
=========================

# tdp_ram_port_arbiter

Single-clock arbiter that shares one port of the 6144x16 true-dual-port data RAM between two requesters, typically the core load/store unit and the debug/loader interface. It grants one access per cycle, round-robin with optional locked bursts. It drives byte-lane write enables, address and write data into the RAM port, and returns read data with a one-cycle latency. Addresses outside the RAM depth are rejected without touching memory.

## Interface
- DEPTH, 6144, number of 16-bit words; addresses >= DEPTH are out of range
- AW, 13, address width
- BURST_MAX, 4, maximum consecutive grants a locked requester may hold while the other requester waits (>= 1)
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- r0_req / r1_req  in  1  access request, held until granted
- r0_lock / r1_lock  in  1  request to keep grant on the next cycle (burst)
- r0_we / r1_we  in  2  byte-lane write enables; [0]=bits 7:0, [1]=bits 15:8; 2'b00 = read
- r0_addr / r1_addr  in  AW  word address
- r0_wdata / r1_wdata  in  16  write data
- r0_gnt / r1_gnt  out  1  combinational grant; request consumed on the clk edge where req&gnt
- r0_rvalid / r1_rvalid  out  1  read data valid, one cycle after a read grant
- r0_rdata / r1_rdata  out  16  read data; ram_dout when the matching rvalid is high, else 0
- r0_err / r1_err  out  1  one-cycle pulse, one cycle after an out-of-range grant
- ram_we  out  2  to RAM port write enables
- ram_addr  out  AW  to RAM port address
- ram_din  out  16  to RAM port write data
- ram_dout  in  16  from RAM port; reflects the address registered on the previous edge

## Operation
- State: prio (next-preferred requester, 1 bit), owner (last granted requester, 1 bit), burst_cnt (0..BURST_MAX), pend_rd[1:0], pend_err[1:0].
- Arbitration, combinational, each cycle:
  - If only one requester has req high, it is granted.
  - If both request and the owner was granted last cycle with lock high and burst_cnt < BURST_MAX, the owner is granted.
  - Otherwise the requester selected by prio is granted.
- At most one gnt is high. Both gnt are 0 while rst is high.
- On a grant to requester n:
  - owner <= n.
  - prio <= ~n.
  - burst_cnt <= (owner==n and the previous cycle was a grant) ? burst_cnt+1 : 1.
- A cycle with no grant clears burst_cnt to 0.
- In-range grant:
  - ram_we = rN_we, ram_addr = rN_addr, ram_din = rN_wdata.
  - pend_rd[n] <= (rN_we==2'b00).
- Out-of-range grant (rN_addr >= DEPTH):
  - ram_we = 0, ram_addr = 0.
  - pend_err[n] <= 1.
  - pend_rd[n] <= (rN_we==2'b00), so a read still returns rvalid, with rdata forced to 0.
- Idle: ram_we = 0, ram_addr = 0, ram_din = 0.
- rN_rvalid = pend_rd[n]. rN_err = pend_err[n]. Both are cleared the cycle after they are set unless a new qualifying grant occurs.
- Writes produce no rvalid. Partial writes (we = 01 or 10) modify only the enabled lane.

## Timing
- Reset values: all gnt, rvalid and err outputs 0; all rdata 0; ram_we 0; ram_addr 0; ram_din 0; prio=0; owner=0; burst_cnt=0.
- Read latency is 1: grant in cycle T gives rvalid/rdata in cycle T+1. Back-to-back reads give one result per cycle.
- Write takes effect at the edge ending the grant cycle. A read of the same address granted in the next cycle returns the new data.
- Simultaneous requests with no lock alternate every cycle, starting with r0 after reset.
- Lock ceiling: with both requesting and r0 locked, r0 gets BURST_MAX consecutive grants, then r1 is granted. A single requester with lock is never limited.
- Reset asserted mid-operation:
  - Pending rvalid and err are dropped at the next edge.
  - A write granted in the cycle rst is high does not occur, because gnt and ram_we are 0.
- A requester changing its address or data while req is high and ungranted has no effect. Only the values present in the grant cycle are used.

## Test plan
- Reset, then r0 writes 16'hA5C3 to address 12 (we=11), then r0 reads address 12 -> r0_gnt high each cycle; r0_rvalid high exactly one cycle after the read grant with r0_rdata=16'hA5C3; r1 outputs stay 0.
- Byte lanes: write 16'hFFFF to address 5, then we=01 with data 16'h1234, then read -> 16'hFF34.
- Both requesting reads continuously with lock=0 -> grants alternate r0,r1,r0,r1; each rvalid follows its own grant by one cycle.
- BURST_MAX=4, both requesting, r0_lock=1 -> r0 granted 4 cycles, r1 granted in cycle 5, r0 granted in cycle 6.
- r1 reads address 6144 and writes address 8191 -> ram_we stays 0; r1_err pulses one cycle after each grant; the read also returns r1_rvalid with r1_rdata=0; memory contents are unchanged.
- Assert rst for one cycle, in the cycle after an r0 read grant and while r1 is requesting -> r0_rvalid low after the edge, no grant during rst, prio returns to r0.

Source files
------------

// File: rtl/tdp_ram_port_arbiter.sv
// rtl/tdp_ram_port_arbiter.sv - two-requester round-robin arbiter for one port of the 6144x16 data RAM
//
// Purpose: grants one of two requesters access to a single RAM port each
// cycle. The default policy is round-robin. A requester can hold the port
// for a locked burst, up to BURST_MAX consecutive grants while the other
// requester waits. The arbiter drives byte-lane write enables, address and
// write data to the RAM. Read data returns one cycle after the grant.
// Addresses at or above DEPTH are rejected with an err pulse, and the
// memory is not touched.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   rN_req/lock/we/addr/wdata  requester N access request (held until granted)
//   rN_gnt                   combinational grant; request consumed on req&gnt edge
//   rN_rvalid/rdata          read result, one cycle after a read grant
//   rN_err                   one-cycle pulse after an out-of-range grant
//   ram_we/addr/din          to RAM port
//   ram_dout                 from RAM port (address registered on previous edge)

module tdp_ram_port_arbiter #(
    parameter int DEPTH     = 6144,
    parameter int AW        = 13,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic [1:0]    r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [15:0]   r0_wdata,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic [1:0]    r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [15:0]   r1_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [15:0]   r0_rdata,
    output logic          r0_err,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [15:0]   r1_rdata,
    output logic          r1_err,
    output logic [1:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_din,
    input  logic [15:0]   ram_dout
);

    localparam int CW = $clog2(BURST_MAX + 1);

    logic          r_prio;
    logic          r_owner;
    logic          r_lock_held;
    logic [CW-1:0] r_burst_cnt;
    logic [1:0]    r_pend_rd;
    logic [1:0]    r_pend_err;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_sel;
    logic          w_lock;
    logic [1:0]    w_we;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_wdata;
    logic          w_oor;
    logic          w_is_rd;
    logic          w_burst_ok;

    // A non-zero burst count means the owner was granted in the previous
    // cycle, because any idle cycle clears the count.
    assign w_burst_ok = r_lock_held && (r_burst_cnt != '0) &&
                        (r_burst_cnt < CW'(BURST_MAX));

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (r0_req && !r1_req) begin
                w_gnt0 = 1'b1;
            end else if (r1_req && !r0_req) begin
                w_gnt1 = 1'b1;
            end else if (r0_req && r1_req) begin
                if (w_burst_ok) begin
                    w_gnt0 = !r_owner;
                    w_gnt1 = r_owner;
                end else begin
                    w_gnt0 = !r_prio;
                    w_gnt1 = r_prio;
                end
            end
        end
    end

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_sel   = w_gnt1;
    assign w_lock  = w_sel ? r1_lock  : r0_lock;
    assign w_we    = w_sel ? r1_we    : r0_we;
    assign w_addr  = w_sel ? r1_addr  : r0_addr;
    assign w_wdata = w_sel ? r1_wdata : r0_wdata;
    assign w_oor   = (w_addr >= AW'(DEPTH));
    assign w_is_rd = (w_we == 2'b00);

    assign r0_gnt = w_gnt0;
    assign r1_gnt = w_gnt1;

    // The RAM port sees only in-range grants. Everything else parks at
    // zero so that a rejected write cannot reach the memory.
    always_comb begin
        ram_we   = 2'b00;
        ram_addr = '0;
        ram_din  = 16'h0000;
        if (w_any && !w_oor) begin
            ram_we   = w_we;
            ram_addr = w_addr;
            ram_din  = w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= 1'b0;
            r_owner     <= 1'b0;
            r_lock_held <= 1'b0;
            r_burst_cnt <= '0;
            r_pend_rd   <= 2'b00;
            r_pend_err  <= 2'b00;
        end else begin
            if (w_any) begin
                r_owner     <= w_sel;
                r_prio      <= ~w_sel;
                r_lock_held <= w_lock;
                // Saturate so that a lone locked requester can keep the
                // port indefinitely without the count wrapping.
                if ((r_owner == w_sel) && (r_burst_cnt != '0)) begin
                    if (r_burst_cnt < CW'(BURST_MAX)) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end else begin
                    r_burst_cnt <= CW'(1);
                end
            end else begin
                r_lock_held <= 1'b0;
                r_burst_cnt <= '0;
            end
            r_pend_rd  <= {w_gnt1 & w_is_rd, w_gnt0 & w_is_rd};
            r_pend_err <= {w_gnt1 & w_oor,   w_gnt0 & w_oor};
        end
    end

    assign r0_rvalid = r_pend_rd[0];
    assign r1_rvalid = r_pend_rd[1];
    assign r0_err    = r_pend_err[0];
    assign r1_err    = r_pend_err[1];

    // An out-of-range read still returns rvalid. The RAM output then holds
    // whatever is at address 0, so the data is forced to zero.
    assign r0_rdata = (r_pend_rd[0] && !r_pend_err[0]) ? ram_dout : 16'h0000;
    assign r1_rdata = (r_pend_rd[1] && !r_pend_err[1]) ? ram_dout : 16'h0000;

endmodule
